// File: rtl/aritmetico_pkg.sv
// aritmetico_pkg: FSM state encoding and operation mode constants for the digit-serial adder.
package aritmetico_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_NEG = 2'b10;
  localparam logic [1:0] MODE_INC = 2'b11;
endpackage

// File: rtl/aritmetico_secuencial_sumador_digito.sv
// sumador_digito: combinational DIGIT-bit ripple adder with carry in/out.
module sumador_digito #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);
  logic [DIGIT:0] c;
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[DIGIT];
  end
endmodule

// File: rtl/aritmetico_secuencial.sv
// aritmetico_secuencial: digit-serial add/sub/neg/inc unit, DIGIT result bits per cycle,
// valid/ready handshake on both sides and registered result flags.
module aritmetico_secuencial
  import aritmetico_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             f1,
  input  logic             f0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             Z,
  output logic             N,
  output logic             V
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW = NDIG > 1 ? $clog2(NDIG) : 1;
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("WIDTH must be an integer multiple of DIGIT");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, s_q, s_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  sumador_digito #(.DIGIT(DIGIT)) u_sumador (
    .a   (x_q[cnt_q*DIGIT +: DIGIT]),
    .b   (y_q[cnt_q*DIGIT +: DIGIT]),
    .cin (carry_q),
    .sum (dsum),
    .cout(dcout)
  );
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    case (state_q)
      IDLE: if (in_valid) begin
        x_d     = f1 ? '0 : A;
        y_d     = (f1 ^ f0) ? ~B : B;
        carry_d = f1 | f0;
        s_d     = '0;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        s_d[cnt_q*DIGIT +: DIGIT] = dsum;
        carry_d = dcout;
        cnt_d   = cnt_q + 1'b1;
        // flags are captured once, when the last digit lands
        if (cnt_q == KW'(NDIG - 1)) begin
          state_d = DONE;
          c_d     = dcout;
          z_d     = s_d == '0;
          n_d     = s_d[WIDTH-1];
          v_d     = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (s_d[WIDTH-1] != x_q[WIDTH-1]);
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign S = s_q;
  assign C = c_q;
  assign Z = z_q;
  assign N = n_q;
  assign V = v_q;
endmodule

// File: tb/tb_aritmetico_secuencial.sv
// tb_aritmetico_secuencial: scoreboard bench; expected results queued at accept, checked on output handshake.
module tb_aritmetico_secuencial;
  typedef struct packed {
    logic [31:0] s;
    logic        c, z, n, v;
  } exp_t;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1, f1 = 0, f0 = 0;
  logic [31:0] a_in = 0, b_in = 0;
  logic        in_ready, out_valid, c_o, z_o, n_o, v_o;
  logic [31:0] s_o;
  int          errors = 0, checks = 0, cyc = 0;
  exp_t        q[$];
  exp_t        mon_e;
  aritmetico_secuencial #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .f1(f1), .f0(f0),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(s_o), .C(c_o), .Z(z_o), .N(n_o), .V(v_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got S=0x%08h with empty scoreboard", s_o);
      end else begin
        mon_e = q.pop_front();
        chk("S", s_o, mon_e.s);
        chk("C", 32'(c_o), 32'(mon_e.c));
        chk("Z", 32'(z_o), 32'(mon_e.z));
        chk("N", 32'(n_o), 32'(mon_e.n));
        chk("V", 32'(v_o), 32'(mon_e.v));
      end
    end
  end
  task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                      input exp_t e, output int acc);
    int n = 0;
    @(negedge clk);
    {f1, f0} = m;
    a_in = a;
    b_in = b;
    in_valid = 1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    q.push_back(e);
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 0);
  endtask
  int t0, t1, t2, lat;
  logic [31:0] held;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_S", s_o, 0);
    chk("rst_flags", {28'd0, c_o, z_o, n_o, v_o}, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst = 0;
    chk("rst_in_ready", 32'(in_ready), 1);
    send(2'b00, 30, 7, '{37, 0, 0, 0, 0}, t0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 8);
    drain();
    send(2'b01, 30, 7, '{23, 1, 0, 0, 0}, t0);
    send(2'b10, 32'h1234, 7, '{32'hFFFFFFF9, 0, 0, 1, 0}, t0);
    send(2'b11, 32'd123, 32'hFFFFFFFF, '{0, 1, 1, 0, 0}, t0);
    send(2'b00, 32'h7FFFFFFF, 1, '{32'h80000000, 0, 0, 1, 1}, t0);
    send(2'b01, 5, 5, '{0, 1, 1, 0, 0}, t0);
    send(2'b01, 32'h80000000, 1, '{32'h7FFFFFFF, 1, 0, 0, 1}, t0);
    send(2'b00, 32'hFFFFFFFF, 1, '{0, 1, 1, 0, 0}, t0);
    drain();
    out_ready = 0;
    send(2'b00, 30, 7, '{37, 0, 0, 0, 0}, t0);
    repeat (9) @(negedge clk);
    held = s_o;
    for (int i = 0; i < 5; i++) begin
      a_in = 32'hDEAD0000 + i;
      b_in = 32'h0000BEEF;
      {f1, f0} = 2'b11;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_S", s_o, 37);
    end
    out_ready = 1;
    drain();
    chk("idle_keeps_S", s_o, 37);
    @(negedge clk);
    {f1, f0} = 2'b00;
    a_in = 30;
    b_in = 7;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midcalc_rst_S", s_o, 0);
    chk("midcalc_rst_flags", {28'd0, c_o, z_o, n_o, v_o}, 0);
    chk("midcalc_rst_out_valid", 32'(out_valid), 0);
    chk("midcalc_rst_in_ready", 32'(in_ready), 1);
    send(2'b00, 30, 7, '{37, 0, 0, 0, 0}, t0);
    drain();
    send(2'b00, 1, 2, '{3, 0, 0, 0, 0}, t0);
    in_valid = 1;
    send(2'b01, 10, 3, '{7, 1, 0, 0, 0}, t1);
    in_valid = 1;
    send(2'b11, 0, 5, '{6, 0, 0, 0, 0}, t2);
    chk("b2b_gap1", t1 - t0, 10);
    chk("b2b_gap2", t2 - t1, 10);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
